// File: rtl/matrix_addsub_seq.sv
// Sequential NxN matrix add/subtract, one element per clock.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready accept a, b, op, sat;
// out_valid/out_ready hand back res and ovf (overflow or borrow seen).
module matrix_addsub_seq #(
    parameter int N  = 2,
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*N*DW-1:0] a,
    input  logic [N*N*DW-1:0] b,
    input  logic              op,
    input  logic              sat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*N*DW-1:0] res,
    output logic              ovf
);

    localparam int NE = N * N;
    localparam int CW = (NE > 1) ? $clog2(NE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;
    logic   accept;

    logic [CW-1:0]    cnt;
    logic [NE*DW-1:0] a_q;
    logic [NE*DW-1:0] b_q;
    logic             op_q;
    logic             sat_q;
    logic             ovf_q;

    logic [DW-1:0] a_el [NE];
    logic [DW-1:0] b_el [NE];
    logic [DW-1:0] r_el [NE];

    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic [DW:0]   sum;
    logic [DW:0]   dif;
    logic [DW-1:0] rv;
    logic          flag;

    // Element k sits at the MSB end for k=0 (row-major, [0][0] first).
    for (genvar k = 0; k < NE; k++) begin : g_el
        assign a_el[k] = a_q[(NE-1-k)*DW +: DW];
        assign b_el[k] = b_q[(NE-1-k)*DW +: DW];
        assign res[(NE-1-k)*DW +: DW] = r_el[k];
    end

    assign ovf = ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // One DW+1 bit add and subtract; bit DW is carry out or borrow.
    always_comb begin
        ea   = a_el[cnt];
        eb   = b_el[cnt];
        sum  = {1'b0, ea} + {1'b0, eb};
        dif  = {1'b0, ea} - {1'b0, eb};
        flag = 1'b0;
        rv   = '0;
        if (!op_q) begin
            flag = sum[DW];
            rv   = (flag && sat_q) ? '1 : sum[DW-1:0];
        end else begin
            flag = dif[DW];
            rv   = (flag && sat_q) ? '0 : dif[DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= 1'b0;
            sat_q <= 1'b0;
            ovf_q <= 1'b0;
            for (int i = 0; i < NE; i++) begin
                r_el[i] <= '0;
            end
        end else if (accept) begin
            cnt   <= '0;
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            sat_q <= sat;
            ovf_q <= 1'b0;
            for (int i = 0; i < NE; i++) begin
                r_el[i] <= '0;
            end
        end else if (state == RUN) begin
            r_el[cnt] <= rv;
            ovf_q     <= ovf_q | flag;
            if (cnt != LAST) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_matrix_addsub_seq.sv
// Directed bench for matrix_addsub_seq: N=2/DW=8 and N=3/DW=16 instances.
// Each scenario task drives its stimulus and checks results inline.
module tb_matrix_addsub_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst2, iv2, ir2, op2, sat2, ov2, or2, ovf2;
    logic [31:0] a2, b2, res2;

    logic         rst3, iv3, ir3, op3, sat3, ov3, or3, ovf3;
    logic [143:0] a3, b3, res3;

    int checks   = 0;
    int failures = 0;

    matrix_addsub_seq #(.N(2), .DW(8)) u2 (
        .clk(clk), .rst_n(rst2),
        .in_valid(iv2), .in_ready(ir2),
        .a(a2), .b(b2), .op(op2), .sat(sat2),
        .out_valid(ov2), .out_ready(or2),
        .res(res2), .ovf(ovf2)
    );

    matrix_addsub_seq #(.N(3), .DW(16)) u3 (
        .clk(clk), .rst_n(rst3),
        .in_valid(iv3), .in_ready(ir3),
        .a(a3), .b(b3), .op(op3), .sat(sat3),
        .out_valid(ov3), .out_ready(or3),
        .res(res3), .ovf(ovf3)
    );

    // Present one operand set to the 2x2 instance and wait for DONE.
    // lat counts edges from acceptance (inclusive) to out_valid.
    task automatic start2(input logic [31:0] ta, input logic [31:0] tb_,
                          input logic top, input logic tsat,
                          output int lat, output int bad);
        a2 = ta; b2 = tb_; op2 = top; sat2 = tsat; iv2 = 1'b1;
        @(posedge clk); #1;
        iv2 = 1'b0;
        lat = 1;
        bad = 0;
        while (!ov2 && lat < 100) begin
            if (ir2) bad++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic ack2;
        or2 = 1'b1;
        @(posedge clk); #1;
        or2 = 1'b0;
    endtask

    task automatic test_reset;
        rst2 = 1'b0; iv2 = 1'b0; or2 = 1'b0;
        a2 = 32'hDEADBEEF; b2 = 32'h12345678; op2 = 1'b0; sat2 = 1'b0;
        rst3 = 1'b0; iv3 = 1'b0; or3 = 1'b0;
        a3 = '1; b3 = '1; op3 = 1'b0; sat3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ir2 !== 1'b1) begin
            failures++; $display("FAIL rst_in_ready2 got=%b exp=1", ir2);
        end
        checks++;
        if (ov2 !== 1'b0) begin
            failures++; $display("FAIL rst_out_valid2 got=%b exp=0", ov2);
        end
        checks++;
        if (res2 !== 32'h0) begin
            failures++; $display("FAIL rst_res2 got=%h exp=0", res2);
        end
        checks++;
        if (ovf2 !== 1'b0) begin
            failures++; $display("FAIL rst_ovf2 got=%b exp=0", ovf2);
        end
        checks++;
        if (ir3 !== 1'b1 || ov3 !== 1'b0) begin
            failures++; $display("FAIL rst_hs3 got=%b%b exp=10", ir3, ov3);
        end
        checks++;
        if (res3 !== 144'h0 || ovf3 !== 1'b0) begin
            failures++; $display("FAIL rst_res3 got=%h/%b exp=0/0", res3, ovf3);
        end
        rst2 = 1'b1;
        rst3 = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add;
        int lat, bad;
        start2(32'h01020304, 32'h10203040, 1'b0, 1'b0, lat, bad);
        checks++;
        if (res2 !== 32'h11223344) begin
            failures++; $display("FAIL add_res got=%h exp=11223344", res2);
        end
        checks++;
        if (ovf2 !== 1'b0) begin
            failures++; $display("FAIL add_ovf got=%b exp=0", ovf2);
        end
        checks++;
        if (lat != 5) begin
            failures++; $display("FAIL add_latency got=%0d exp=5", lat);
        end
        checks++;
        if (bad != 0 || ir2 !== 1'b0) begin
            failures++; $display("FAIL add_in_ready got=%0d/%b exp=0/0", bad, ir2);
        end
        ack2();
        checks++;
        if (ov2 !== 1'b0 || ir2 !== 1'b1) begin
            failures++; $display("FAIL add_release got=%b%b exp=01", ov2, ir2);
        end
    endtask

    task automatic test_add_overflow;
        int lat, bad;
        start2(32'hFF800102, 32'h01800304, 1'b0, 1'b0, lat, bad);
        checks++;
        if (res2 !== 32'h00000406 || ovf2 !== 1'b1) begin
            failures++;
            $display("FAIL addovf_wrap got=%h/%b exp=00000406/1", res2, ovf2);
        end
        ack2();
        start2(32'hFF800102, 32'h01800304, 1'b0, 1'b1, lat, bad);
        checks++;
        if (res2 !== 32'hFFFF0406 || ovf2 !== 1'b1) begin
            failures++;
            $display("FAIL addovf_sat got=%h/%b exp=FFFF0406/1", res2, ovf2);
        end
        ack2();
    endtask

    task automatic test_sub;
        int lat, bad;
        start2(32'h10203040, 32'h01020304, 1'b1, 1'b0, lat, bad);
        checks++;
        if (res2 !== 32'h0F1E2D3C || ovf2 !== 1'b0) begin
            failures++;
            $display("FAIL sub_plain got=%h/%b exp=0F1E2D3C/0", res2, ovf2);
        end
        ack2();
        start2(32'h00100000, 32'h01050000, 1'b1, 1'b0, lat, bad);
        checks++;
        if (res2 !== 32'hFF0B0000 || ovf2 !== 1'b1) begin
            failures++;
            $display("FAIL sub_wrap got=%h/%b exp=FF0B0000/1", res2, ovf2);
        end
        ack2();
        start2(32'h00100000, 32'h01050000, 1'b1, 1'b1, lat, bad);
        checks++;
        if (res2 !== 32'h000B0000 || ovf2 !== 1'b1) begin
            failures++;
            $display("FAIL sub_sat got=%h/%b exp=000B0000/1", res2, ovf2);
        end
        ack2();
    endtask

    task automatic test_boundary;
        int lat, bad;
        start2(32'hFF7F0000, 32'h00800000, 1'b0, 1'b1, lat, bad);
        checks++;
        if (res2 !== 32'hFFFF0000 || ovf2 !== 1'b0) begin
            failures++;
            $display("FAIL bnd_add_max got=%h/%b exp=FFFF0000/0", res2, ovf2);
        end
        ack2();
        start2(32'h55AA0102, 32'h55AA0102, 1'b1, 1'b1, lat, bad);
        checks++;
        if (res2 !== 32'h00000000 || ovf2 !== 1'b0) begin
            failures++;
            $display("FAIL bnd_sub_zero got=%h/%b exp=00000000/0", res2, ovf2);
        end
        ack2();
    endtask

    task automatic test_backpressure;
        int lat, bad;
        start2(32'h01020304, 32'h10203040, 1'b0, 1'b0, lat, bad);
        for (int i = 0; i < 4; i++) begin
            a2  = ~a2;
            b2  = ~b2;
            iv2 = ~iv2;
            op2 = ~op2;
            @(posedge clk); #1;
            checks++;
            if (res2 !== 32'h11223344 || ovf2 !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_res c%0d got=%h/%b exp=11223344/0",
                         i, res2, ovf2);
            end
            checks++;
            if (ov2 !== 1'b1 || ir2 !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_hs c%0d got=%b%b exp=10", i, ov2, ir2);
            end
        end
        iv2 = 1'b0;
        ack2();
        checks++;
        if (ov2 !== 1'b0 || ir2 !== 1'b1) begin
            failures++; $display("FAIL bp_release got=%b%b exp=01", ov2, ir2);
        end
        start2(32'hFF800102, 32'h01800304, 1'b0, 1'b1, lat, bad);
        checks++;
        if (res2 !== 32'hFFFF0406 || ovf2 !== 1'b1 || lat != 5) begin
            failures++;
            $display("FAIL bp_next got=%h/%b/%0d exp=FFFF0406/1/5",
                     res2, ovf2, lat);
        end
        ack2();
    endtask

    task automatic test_reset_mid_run;
        int seen;
        a2 = 32'h01020304; b2 = 32'h10203040; op2 = 1'b0; sat2 = 1'b0;
        iv2 = 1'b1;
        @(posedge clk); #1;
        iv2 = 1'b0;
        @(posedge clk); #1;
        rst2 = 1'b0;
        @(posedge clk); #1;
        rst2 = 1'b1;
        checks++;
        if (ov2 !== 1'b0 || ir2 !== 1'b1) begin
            failures++; $display("FAIL midrst_hs got=%b%b exp=01", ov2, ir2);
        end
        checks++;
        if (res2 !== 32'h0 || ovf2 !== 1'b0) begin
            failures++;
            $display("FAIL midrst_res got=%h/%b exp=0/0", res2, ovf2);
        end
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ov2) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++; $display("FAIL midrst_no_out got=%0d exp=0", seen);
        end
    endtask

    task automatic test_n3;
        int lat;
        logic [15:0] exp_el;
        a3 = '0;
        b3 = '0;
        for (int k = 0; k < 9; k++) begin
            a3[(8-k)*16 +: 16] = 16'(k);
        end
        b3[15:0] = 16'hFFFF;
        op3 = 1'b0; sat3 = 1'b1; iv3 = 1'b1;
        @(posedge clk); #1;
        iv3 = 1'b0;
        lat = 1;
        while (!ov3 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != 10) begin
            failures++; $display("FAIL n3_latency got=%0d exp=10", lat);
        end
        for (int k = 0; k < 9; k++) begin
            exp_el = (k == 8) ? 16'hFFFF : 16'(k);
            checks++;
            if (res3[(8-k)*16 +: 16] !== exp_el) begin
                failures++;
                $display("FAIL n3_el%0d got=%h exp=%h",
                         k, res3[(8-k)*16 +: 16], exp_el);
            end
        end
        checks++;
        if (ovf3 !== 1'b1) begin
            failures++; $display("FAIL n3_ovf got=%b exp=1", ovf3);
        end
        or3 = 1'b1;
        @(posedge clk); #1;
        or3 = 1'b0;
        checks++;
        if (ov3 !== 1'b0 || ir3 !== 1'b1) begin
            failures++; $display("FAIL n3_release got=%b%b exp=01", ov3, ir3);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_add_overflow();
        test_sub();
        test_boundary();
        test_backpressure();
        test_reset_mid_run();
        test_n3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
